rr_dispatch: RTL

Round-robin dispatcher: accepts one stream of data words and delivers each word to exactly one of N consumer ports, rotating fairly among the enabled ports. It is the distribution counterpart of the round-robin arbiter: the arbiter merges many requesters into one channel, while this block fans one producer out to many consumers. Typical use is issue-side distribution of decoded instructions to identical reservation-station banks. A 2-entry internal buffer decouples producer and consumer backpressure.

---
 rtl/rr_dispatch_pkg.sv | 12 +
 rtl/rr_pick.sv | 38 +++
 rtl/rr_dispatch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rr_dispatch_pkg.sv
// Shared constants and head-state encoding for the round-robin dispatcher.
package rr_dispatch_pkg;

   localparam int unsigned DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY      = 2'd0,
      UNASSIGNED = 2'd1,
      OFFERED    = 2'd2
   } head_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set bit of mask at or after start, searched cyclically.
module rr_pick #(
   parameter int unsigned N      = 4,
   parameter int unsigned BW_IDX = $clog2(N)
) (
   input  logic [N-1:0]      mask,
   input  logic [BW_IDX-1:0] start,
   output logic [N-1:0]      grant,
   output logic [BW_IDX-1:0] idx,
   output logic              none
);

   localparam int unsigned IW = BW_IDX + 1;

   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW-1:0] sum;

   // rotate so start lands at bit 0, take lowest set bit, rotate the index back
   always_comb begin
      rot  = N'({mask, mask} >> start);
      off  = '0;
      none = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off  = IW'(i);
            none = 1'b0;
         end
      end
      sum = off + IW'(start);
      if (sum >= IW'(N)) begin
         sum = sum - IW'(N);
      end
      idx   = sum[BW_IDX-1:0];
      grant = none ? '0 : (N'(1) << idx);
   end

endmodule

// File: rtl/rr_dispatch.sv
// Round-robin dispatcher: one producer stream fanned out to N consumer ports
// through a 2-entry buffer, rotating among enabled ports.
module rr_dispatch
   import rr_dispatch_pkg::*;
#(
   parameter  int unsigned N      = 4,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BW_IDX = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   input  logic [N-1:0]      i_enable,
   output logic              o_valid,
   output logic [N-1:0]      o_target,
   output logic [BW_IDX-1:0] o_target_idx,
   output logic [DATA_W-1:0] o_data,
   input  logic [N-1:0]      i_ready,
   output logic [1:0]        o_count
);

   head_state_e       state_q, state_d;
   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
   logic [1:0]        count_q, count_d;
   logic [BW_IDX-1:0] ptr_q, ptr_d;
   logic [BW_IDX-1:0] tidx_q, tidx_d;
   logic [N-1:0]      tgt_q, tgt_d;
   logic              valid_q, valid_d;

   logic              push_c, pop_c, head_new_c;
   logic [N-1:0]      pick_grant_c;
   logic [BW_IDX-1:0] pick_idx_c;
   logic              pick_none_c;

   assign o_ready = ~rst & (count_q < 2'(DEPTH));
   assign push_c  = i_valid & o_ready;
   assign pop_c   = (state_q == OFFERED) & (|(tgt_q & i_ready));

   // selection sees the pointer after any same-cycle delivery
   rr_pick #(.N(N), .BW_IDX(BW_IDX)) u_pick (
      .mask  (i_enable),
      .start (ptr_d),
      .grant (pick_grant_c),
      .idx   (pick_idx_c),
      .none  (pick_none_c)
   );

   always_comb begin
      state_d = state_q;
      data0_d = data0_q;
      data1_d = data1_q;
      ptr_d   = ptr_q;
      tidx_d  = tidx_q;
      tgt_d   = tgt_q;

      if (pop_c) begin
         ptr_d = (tidx_q == BW_IDX'(N - 1)) ? '0 : tidx_q + BW_IDX'(1);
      end
      count_d = count_q + 2'(push_c) - 2'(pop_c);

      // entry 0 is always the head; entry 1 only holds a waiting second word
      case (count_q)
         2'd0: begin
            if (push_c) data0_d = i_data;
         end
         2'd1: begin
            if (push_c && pop_c) data0_d = i_data;
            else if (push_c)     data1_d = i_data;
         end
         default: begin
            if (pop_c) data0_d = data1_q;
         end
      endcase

      head_new_c = ((state_q == EMPTY) && push_c) || (pop_c && (count_d != 2'd0));

      if (head_new_c || (state_q == UNASSIGNED)) begin
         state_d = pick_none_c ? UNASSIGNED : OFFERED;
         tgt_d   = pick_grant_c;
         tidx_d  = pick_none_c ? '0 : pick_idx_c;
      end else if (pop_c) begin
         state_d = EMPTY;
         tgt_d   = '0;
         tidx_d  = '0;
      end

      valid_d = (state_d == OFFERED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         data0_q <= '0;
         data1_q <= '0;
         count_q <= '0;
         ptr_q   <= '0;
         tidx_q  <= '0;
         tgt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         tidx_q  <= tidx_d;
         tgt_q   <= tgt_d;
         valid_q <= valid_d;
      end
   end

   assign o_valid      = valid_q;
   assign o_target     = tgt_q;
   assign o_target_idx = tidx_q;
   assign o_data       = data0_q;
   assign o_count      = count_q;

endmodule
